// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-I subset CPU.
// - Opcode and funct field encodings of the supported instructions.
// - FSM state enum (FETCH, EXEC, MEM, WB, HALT).
// - ALU operation enum.
package mips_cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASSB
    } alu_op_t;

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32 x 32-bit general purpose register file.
// - clk, reset            : clock, synchronous active-high clear of all registers
// - i_raddr_a/o_rdata_a   : asynchronous read port A
// - i_raddr_b/o_rdata_b   : asynchronous read port B
// - i_we/i_waddr/i_wdata  : synchronous write port; writes to register 0 are dropped
// - o_v0                  : live copy of register 2
module mips_cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_v0
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Register 0 is cleared by reset and never written, so it always reads 0.
    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];
    assign o_v0      = r_regs[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multi-cycle MIPS-I subset CPU with a single Avalon-MM master port shared by
// instruction fetch and data access. Jumping to address 0 halts the core once
// the delay slot has executed.
// - clk, reset            : clock, synchronous active-high reset
// - active                : 1 while running, 0 once halted
// - register_v0           : live copy of GPR $2
// - address/byteenable    : word-aligned byte address and byte lanes
// - read/write            : mutually exclusive transfer requests
// - waitrequest           : slave stall; transfer completes on an edge where it is 0
// - readdata/writedata    : bus data
module mips_cpu_bus
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] writedata
);

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_target, r_maddr, r_wdata, r_load_data;
    logic        r_delay_pending, r_is_load;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_rs_val, w_rt_val, w_imm_s, w_imm_z, w_pc4, w_pc8;
    logic [31:0] w_opa, w_opb, w_alu_res, w_jtarget, w_next_pc;
    alu_op_t     w_alu_op;
    logic        w_wen, w_jump, w_is_mem, w_is_load;
    logic [4:0]  w_wdst;
    logic        w_rf_we, w_bus_rd, w_bus_wr;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    state_t      w_retire_state;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_fn    = r_ir[5:0];
    assign w_imm_s = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm_z = {16'h0000, r_ir[15:0]};
    assign w_pc4   = r_pc + 32'd4;
    assign w_pc8   = r_pc + 32'd8;

    mips_cpu_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .o_v0      (register_v0)
    );

    // Decode: unknown opcodes/functs fall through the defaults and act as NOP.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_opa     = w_rs_val;
        w_opb     = w_rt_val;
        w_shamt   = r_ir[10:6];
        w_wen     = 1'b0;
        w_wdst    = w_rd;
        w_jump    = 1'b0;
        w_jtarget = w_rs_val;
        w_is_mem  = 1'b0;
        w_is_load = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                w_wen = 1'b1;
                case (w_fn)
                    FN_SLL:  begin w_alu_op = ALU_SLL; w_opa = w_rt_val; end
                    FN_SRL:  begin w_alu_op = ALU_SRL; w_opa = w_rt_val; end
                    FN_SRA:  begin w_alu_op = ALU_SRA; w_opa = w_rt_val; end
                    FN_SLLV: begin w_alu_op = ALU_SLL; w_opa = w_rt_val; w_shamt = w_rs_val[4:0]; end
                    FN_SRLV: begin w_alu_op = ALU_SRL; w_opa = w_rt_val; w_shamt = w_rs_val[4:0]; end
                    FN_SRAV: begin w_alu_op = ALU_SRA; w_opa = w_rt_val; w_shamt = w_rs_val[4:0]; end
                    FN_JR:   begin w_wen = 1'b0; w_jump = 1'b1; end
                    FN_JALR: begin w_jump = 1'b1; w_alu_op = ALU_PASSB; w_opb = w_pc8; end
                    FN_ADDU: w_alu_op = ALU_ADD;
                    FN_SUBU: w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_XOR:  w_alu_op = ALU_XOR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    FN_SLTU: w_alu_op = ALU_SLTU;
                    default: w_wen = 1'b0;
                endcase
            end
            OP_J:     begin w_jump = 1'b1; w_jtarget = {w_pc4[31:28], r_ir[25:0], 2'b00}; end
            OP_JAL:   begin
                w_jump = 1'b1; w_jtarget = {w_pc4[31:28], r_ir[25:0], 2'b00};
                w_wen = 1'b1; w_wdst = 5'd31; w_alu_op = ALU_PASSB; w_opb = w_pc8;
            end
            OP_BEQ:   begin w_jump = (w_rs_val == w_rt_val); w_jtarget = w_pc4 + (w_imm_s << 2); end
            OP_BNE:   begin w_jump = (w_rs_val != w_rt_val); w_jtarget = w_pc4 + (w_imm_s << 2); end
            OP_ADDIU: begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_s; w_alu_op = ALU_ADD;  end
            OP_SLTI:  begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_s; w_alu_op = ALU_SLT;  end
            OP_SLTIU: begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_s; w_alu_op = ALU_SLTU; end
            OP_ANDI:  begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_z; w_alu_op = ALU_AND;  end
            OP_ORI:   begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_z; w_alu_op = ALU_OR;   end
            OP_XORI:  begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_z; w_alu_op = ALU_XOR;  end
            OP_LUI:   begin w_wen = 1'b1; w_wdst = w_rt; w_opb = w_imm_z; w_alu_op = ALU_LUI;  end
            OP_LW:    begin w_is_mem = 1'b1; w_is_load = 1'b1; end
            OP_SW:    w_is_mem = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:   w_alu_res = w_opa + w_opb;
            ALU_SUB:   w_alu_res = w_opa - w_opb;
            ALU_AND:   w_alu_res = w_opa & w_opb;
            ALU_OR:    w_alu_res = w_opa | w_opb;
            ALU_XOR:   w_alu_res = w_opa ^ w_opb;
            ALU_SLT:   w_alu_res = {31'd0, $signed(w_opa) < $signed(w_opb)};
            ALU_SLTU:  w_alu_res = {31'd0, w_opa < w_opb};
            ALU_SLL:   w_alu_res = w_opa << w_shamt;
            ALU_SRL:   w_alu_res = w_opa >> w_shamt;
            ALU_SRA:   w_alu_res = $signed(w_opa) >>> w_shamt;
            ALU_LUI:   w_alu_res = {w_opb[15:0], 16'h0000};
            ALU_PASSB: w_alu_res = w_opb;
            default:   w_alu_res = '0;
        endcase
    end

    // An instruction retires in EXEC, MEM (store) or WB (load). Retiring the
    // delay slot redirects to the pending target, or halts if that target is 0.
    assign w_next_pc      = r_delay_pending ? r_target : w_pc4;
    assign w_retire_state = (r_delay_pending && (r_target == '0)) ? HALT : FETCH;

    assign w_rf_we    = ((r_state == EXEC) && w_wen) || (r_state == WB);
    assign w_rf_waddr = (r_state == WB) ? w_rt : w_wdst;
    assign w_rf_wdata = (r_state == WB) ? r_load_data : w_alu_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FETCH;
            r_pc            <= RESET_VECTOR;
            r_ir            <= '0;
            r_delay_pending <= 1'b0;
            r_target        <= '0;
            r_maddr         <= '0;
            r_wdata         <= '0;
            r_is_load       <= 1'b0;
            r_load_data     <= '0;
        end else begin
            case (r_state)
                FETCH: if (!waitrequest) begin
                    r_ir    <= readdata;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (w_is_mem) begin
                        r_maddr   <= (w_rs_val + w_imm_s) & 32'hFFFF_FFFC;
                        r_wdata   <= w_rt_val;
                        r_is_load <= w_is_load;
                        r_state   <= MEM;
                    end else begin
                        r_pc            <= w_next_pc;
                        r_delay_pending <= 1'b0;
                        r_state         <= w_retire_state;
                    end
                    // Branches never sit in a delay slot, so this cannot clash with a redirect.
                    if (w_jump) begin
                        r_delay_pending <= 1'b1;
                        r_target        <= w_jtarget;
                    end
                end
                MEM: if (!waitrequest) begin
                    if (r_is_load) begin
                        r_load_data <= readdata;
                        r_state     <= WB;
                    end else begin
                        r_pc            <= w_next_pc;
                        r_delay_pending <= 1'b0;
                        r_state         <= w_retire_state;
                    end
                end
                WB: begin
                    r_pc            <= w_next_pc;
                    r_delay_pending <= 1'b0;
                    r_state         <= w_retire_state;
                end
                HALT:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    // Bus strobes decode the registered state so a request is presented in the
    // first cycle after reset falls; gating with reset aborts any transfer at once.
    assign w_bus_rd   = (r_state == FETCH) || ((r_state == MEM) && r_is_load);
    assign w_bus_wr   = (r_state == MEM) && !r_is_load;
    assign read       = !reset && w_bus_rd;
    assign write      = !reset && w_bus_wr;
    assign address    = reset ? '0 :
                        (r_state == FETCH) ? {r_pc[31:2], 2'b00} :
                        (r_state == MEM)   ? r_maddr : '0;
    assign byteenable = (read || write) ? 4'hF : 4'h0;
    assign writedata  = write ? r_wdata : '0;
    assign active     = reset || (r_state != HALT);

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Testbench for mips_cpu_bus: Avalon slave model with programmable wait states,
// a table of small programs with expected $v0 and store traffic, and
// hand-written reset / stall / abort sequences.
module tb_mips_cpu_bus;

    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam logic [31:0] JR0  = 32'h0000_0008;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active, read, write;
    logic        waitrequest = 1'b0;
    logic [31:0] register_v0, address, writedata;
    logic [31:0] readdata = 32'hDEAD_BEEF;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus #(.RESET_VECTOR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .byteenable  (byteenable),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .writedata   (writedata)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [63:0] wr_q [$];
    logic [31:0] v0_q [$];
    int unsigned wait_cfg = 0;
    int unsigned wcnt = 0;
    bit          busy = 1'b0;

    typedef struct {
        int unsigned n;
        logic [31:0] exp_v0;
        int unsigned wcfg;
        bit          has_wr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } vec_t;

    localparam int NVEC = 10;
    vec_t        vecs [NVEC];
    logic [31:0] rom  [NVEC][12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    // Avalon slave: decides waitrequest/readdata at the falling edge so the
    // DUT sees settled values at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            waitrequest = 1'b0;
            busy        = 1'b0;
            readdata    = 32'hDEAD_BEEF;
        end else if (read || write) begin
            check("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
            if (!busy) begin
                busy = 1'b1;
                wcnt = wait_cfg;
            end
            if (wcnt != 0) begin
                waitrequest = 1'b1;
                readdata    = 32'hDEAD_BEEF;
                wcnt--;
            end else begin
                waitrequest = 1'b0;
                busy        = 1'b0;
                if (read) begin
                    readdata = mem_rd(address);
                end else begin
                    readdata = 32'hDEAD_BEEF;
                    mem[address] = writedata;
                    if (wr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%h:%h required=none", address, writedata);
                    end else begin
                        logic [63:0] e;
                        e = wr_q.pop_front();
                        check("wr_addr", address, e[63:32]);
                        check("wr_data", writedata, e[31:0]);
                        check("wr_be", {28'd0, byteenable}, 32'hF);
                    end
                end
            end
        end else begin
            waitrequest = 1'b0;
            busy        = 1'b0;
        end
    end

    task automatic load_prog(input int unsigned k);
        mem.delete();
        for (int i = 0; i < 12; i++) mem[BASE + 32'(4 * i)] = rom[k][i];
    endtask

    task automatic wait_halt(input string tag);
        int unsigned cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (active === 1'b1 && cyc < 3000);
        check({tag, "_halted"}, {31'd0, active}, 32'd0);
    endtask

    task automatic run_prog(input int unsigned k);
        string tag;
        logic [31:0] ev;
        tag = $sformatf("prog%0d", k);
        load_prog(k);
        wait_cfg = vecs[k].wcfg;
        wr_q.delete();
        v0_q.push_back(vecs[k].exp_v0);
        if (vecs[k].has_wr) wr_q.push_back({vecs[k].wr_addr, vecs[k].wr_data});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_halt(tag);
        ev = v0_q.pop_front();
        check({tag, "_v0"}, register_v0, ev);
        check({tag, "_wr_drained"}, 32'(wr_q.size()), 32'd0);
        if (vecs[k].has_wr) check({tag, "_mem"}, mem_rd(vecs[k].wr_addr), vecs[k].wr_data);
        repeat (2) @(negedge clk);
        check({tag, "_halt_quiet"}, {30'd0, read, write}, 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- program table ----
        for (int k = 0; k < NVEC; k++) for (int i = 0; i < 12; i++) rom[k][i] = NOP;

        // 0: ADDIU $2,$0,5; JR $0; NOP
        rom[0][0] = ei(6'h09, 0, 2, 16'd5); rom[0][1] = JR0;
        vecs[0] = '{3, 32'd5, 0, 1'b0, 32'd0, 32'd0};

        // 1: LUI/ORI/SW/LW round trip through memory word 0
        rom[1][0] = ei(6'h0F, 0, 3, 16'h1234); rom[1][1] = ei(6'h0D, 3, 3, 16'h5678);
        rom[1][2] = ei(6'h2B, 4, 3, 16'd0);    rom[1][3] = ei(6'h23, 4, 2, 16'd0);
        rom[1][4] = JR0;
        vecs[1] = '{6, 32'h1234_5678, 0, 1'b1, 32'd0, 32'h1234_5678};

        // 2: BEQ taken, slot executes, one instruction skipped
        rom[2][0] = ei(6'h04, 0, 0, 16'd2);  rom[2][1] = ei(6'h09, 2, 2, 16'd1);
        rom[2][2] = ei(6'h09, 2, 2, 16'd16); rom[2][3] = ei(6'h09, 2, 2, 16'd2);
        rom[2][4] = JR0;
        vecs[2] = '{6, 32'd3, 0, 1'b0, 32'd0, 32'd0};

        // 3: JAL f; NOP; (2 skipped); f: ADDU $2,$31,$0; JR $0; NOP
        rom[3][0] = ej(6'h03, BASE + 32'h10);
        rom[3][2] = ei(6'h09, 2, 2, 16'h0111); rom[3][3] = ei(6'h09, 2, 2, 16'h0111);
        rom[3][4] = er(31, 0, 2, 0, 6'h21);    rom[3][5] = JR0;
        vecs[3] = '{7, BASE + 32'd8, 0, 1'b0, 32'd0, 32'd0};

        // 4: signed/unsigned compares, SRA/SRL, SUBU wrap
        rom[4][0] = ei(6'h09, 0, 5, 16'hFFFF); rom[4][1] = ei(6'h0B, 0, 6, 16'hFFFF);
        rom[4][2] = er(5, 0, 7, 0, 6'h2A);     rom[4][3] = er(0, 5, 8, 4, 6'h03);
        rom[4][4] = er(0, 5, 9, 28, 6'h02);    rom[4][5] = er(6, 7, 2, 0, 6'h21);
        rom[4][6] = er(2, 9, 2, 0, 6'h21);     rom[4][7] = er(2, 8, 2, 0, 6'h23);
        rom[4][8] = JR0;
        vecs[4] = '{10, 32'h0000_0012, 0, 1'b0, 32'd0, 32'd0};

        // 5: write to $0 dropped, XORI zero-extends, BNE taken
        rom[5][0] = ei(6'h09, 0, 0, 16'd7);    rom[5][1] = ei(6'h0E, 0, 2, 16'h8000);
        rom[5][2] = er(2, 0, 2, 0, 6'h21);     rom[5][3] = ei(6'h05, 2, 0, 16'd2);
        rom[5][4] = ei(6'h0D, 2, 2, 16'd1);    rom[5][5] = ei(6'h09, 0, 2, 16'd0);
        rom[5][6] = JR0;
        vecs[5] = '{8, 32'h0000_8001, 0, 1'b0, 32'd0, 32'd0};

        // 6: unaligned SW/LW offsets forced to word 0, with wait states
        rom[6][0] = ei(6'h0F, 0, 3, 16'h1234); rom[6][1] = ei(6'h0D, 3, 3, 16'h5678);
        rom[6][2] = ei(6'h2B, 4, 3, 16'd2);    rom[6][3] = ei(6'h23, 4, 2, 16'd3);
        rom[6][4] = JR0;
        vecs[6] = '{6, 32'h1234_5678, 2, 1'b1, 32'd0, 32'h1234_5678};

        // 7: JALR $2,$9 links PC+8 into rd
        rom[7][0] = ei(6'h0F, 0, 9, 16'hBFC0); rom[7][1] = ei(6'h0D, 9, 9, 16'h0014);
        rom[7][2] = er(9, 0, 2, 0, 6'h09);     rom[7][4] = ei(6'h09, 0, 2, 16'd0);
        rom[7][5] = JR0;
        vecs[7] = '{7, BASE + 32'h10, 0, 1'b0, 32'd0, 32'd0};

        // 8: variable shifts (shift amount 36 -> 4), XOR/OR, SLTI signed
        rom[8][0] = ei(6'h09, 0, 4, 16'hFFF0); rom[8][1] = ei(6'h09, 0, 5, 16'd36);
        rom[8][2] = er(5, 4, 6, 0, 6'h07);     rom[8][3] = er(5, 5, 7, 0, 6'h04);
        rom[8][4] = er(5, 4, 8, 0, 6'h06);     rom[8][5] = er(6, 8, 2, 0, 6'h26);
        rom[8][6] = er(2, 7, 2, 0, 6'h25);     rom[8][7] = ei(6'h0A, 4, 3, 16'hFFFF);
        rom[8][8] = er(2, 3, 2, 0, 6'h21);     rom[8][9] = JR0;
        vecs[8] = '{11, 32'hF000_0241, 0, 1'b0, 32'd0, 32'd0};

        // 9: program 0 again with one wait state on every transfer
        rom[9][0] = ei(6'h09, 0, 2, 16'd5); rom[9][1] = JR0;
        vecs[9] = '{3, 32'd5, 1, 1'b0, 32'd0, 32'd0};

        // ---- reset held 3 cycles, then first fetch ----
        load_prog(0);
        wait_cfg = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_rw", {30'd0, read, write}, 32'd0);
            check("reset_addr", address, 32'd0);
            check("reset_active", {31'd0, active}, 32'd1);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("first_read", {31'd0, read}, 32'd1);
        check("first_addr", address, BASE);
        check("first_be", {28'd0, byteenable}, 32'hF);
        check("first_active", {31'd0, active}, 32'd1);
        check("first_v0", register_v0, 32'd0);

        // ---- table-driven programs ----
        for (int unsigned k = 0; k < NVEC; k++) run_prog(k);

        // ---- fetch stalled 3 cycles: request held stable, IR taken on release ----
        load_prog(0);
        wait_cfg = 3;
        v0_q.push_back(32'd5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall_read%0d", i), {31'd0, read}, 32'd1);
            check($sformatf("stall_addr%0d", i), address, BASE);
            check($sformatf("stall_be%0d", i), {28'd0, byteenable}, 32'hF);
        end
        @(negedge clk);
        check("stall_exec_idle", {30'd0, read, write}, 32'd0);
        wait_halt("stall");
        check("stall_v0", register_v0, v0_q.pop_front());

        // ---- reset mid-transaction drops the request immediately ----
        load_prog(0);
        wait_cfg = 5;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_pre_read", {31'd0, read}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rw", {30'd0, read, write}, 32'd0);
        check("abort_be", {28'd0, byteenable}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cfg = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
